// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package cpu_seq_pkg;

  // Sequencer states; 4-bit encoding leaves room for future states.
  typedef enum logic [3:0] {
    FETCH_REQ  = 4'd0,
    FETCH_WAIT = 4'd1,
    DECODE     = 4'd2,
    EXECUTE    = 4'd3,
    MEM_REQ    = 4'd4,
    MEM_WAIT   = 4'd5,
    WRITEBACK  = 4'd6,
    TRAP       = 4'd7,
    HALT       = 4'd8
  } seq_state_e;

  // Halt reasons reported on halt_code.
  localparam logic [1:0] HALT_EBREAK = 2'b00;
  localparam logic [1:0] HALT_IFU_TO = 2'b01;
  localparam logic [1:0] HALT_LSU_TO = 2'b10;

endpackage

// File: rtl/cpu_seq_ctrl_wait_watchdog.sv
// Bus wait-state watchdog shared by the fetch and memory wait states.
// The count is cleared when a request is accepted and advances on every
// wait cycle without a response. expired_o is high during the TIMEOUT-th
// wait cycle, so the sequencer can still honour a response arriving then.
module wait_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 32'd1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 16'd0;
    end else if (cnt_en_i) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer for the NPC core: drives PC/IR/GPR enables, runs
// the fetch and load/store handshakes, counts retired instructions, traps
// on bus errors and illegal instructions, and halts on ebreak or timeout.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic             ifu_rsp_err,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_is_ebreak,
  input  logic             dec_illegal,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  input  logic             lsu_rsp_err,
  output logic             ir_en,
  output logic             pc_en,
  output logic             pc_sel_trap,
  output logic             gpr_we,
  output logic             halt,
  output logic [1:0]       halt_code,
  output logic [CNT_W-1:0] instret
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic [1:0]       halt_code_q;
  logic [1:0]       halt_code_d;

  logic wd_clr_s;
  logic wd_en_s;
  logic wd_expired_s;

  logic ifu_req_valid_s;
  logic lsu_req_valid_s;
  logic ir_en_s;
  logic pc_en_s;
  logic pc_sel_trap_s;
  logic gpr_we_s;
  logic halt_s;

  wait_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr_s),
    .cnt_en_i  (wd_en_s),
    .expired_o (wd_expired_s)
  );

  // Next-state, counter updates and state-decoded strobes.
  always_comb begin
    state_d         = state_q;
    instret_d       = instret_q;
    halt_code_d     = halt_code_q;
    wd_clr_s        = 1'b0;
    wd_en_s         = 1'b0;
    ifu_req_valid_s = 1'b0;
    lsu_req_valid_s = 1'b0;
    ir_en_s         = 1'b0;
    pc_en_s         = 1'b0;
    pc_sel_trap_s   = 1'b0;
    gpr_we_s        = 1'b0;
    halt_s          = 1'b0;

    case (state_q)
      FETCH_REQ: begin
        ifu_req_valid_s = 1'b1;
        if (ifu_req_ready) begin
          wd_clr_s = 1'b1;
          state_d  = FETCH_WAIT;
        end else begin
          state_d  = FETCH_REQ;
        end
      end

      FETCH_WAIT: begin
        // A response on the expiry cycle still wins over the timeout.
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d = TRAP;
          end else begin
            ir_en_s = 1'b1;
            state_d = DECODE;
          end
        end else if (wd_expired_s) begin
          halt_code_d = HALT_IFU_TO;
          state_d     = HALT;
        end else begin
          wd_en_s = 1'b1;
          state_d = FETCH_WAIT;
        end
      end

      DECODE: begin
        if (dec_illegal) begin
          state_d = TRAP;
        end else if (dec_is_ebreak) begin
          halt_code_d = HALT_EBREAK;
          state_d     = HALT;
        end else begin
          state_d = EXECUTE;
        end
      end

      EXECUTE: begin
        if (dec_is_load || dec_is_store) begin
          state_d = MEM_REQ;
        end else begin
          state_d = WRITEBACK;
        end
      end

      MEM_REQ: begin
        lsu_req_valid_s = 1'b1;
        if (lsu_req_ready) begin
          wd_clr_s = 1'b1;
          state_d  = MEM_WAIT;
        end else begin
          state_d  = MEM_REQ;
        end
      end

      MEM_WAIT: begin
        if (lsu_rsp_valid) begin
          if (lsu_rsp_err) begin
            state_d = TRAP;
          end else begin
            state_d = WRITEBACK;
          end
        end else if (wd_expired_s) begin
          halt_code_d = HALT_LSU_TO;
          state_d     = HALT;
        end else begin
          wd_en_s = 1'b1;
          state_d = MEM_WAIT;
        end
      end

      WRITEBACK: begin
        pc_en_s   = 1'b1;
        gpr_we_s  = !dec_is_store;
        instret_d = instret_q + CNT_W'(1'b1);
        state_d   = FETCH_REQ;
      end

      TRAP: begin
        pc_en_s       = 1'b1;
        pc_sel_trap_s = 1'b1;
        state_d       = FETCH_REQ;
      end

      HALT: begin
        halt_s  = 1'b1;
        state_d = HALT;
      end

      default: begin
        state_d = FETCH_REQ;
      end
    endcase
  end

  // State, retired-instruction counter and halt reason registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH_REQ;
      instret_q   <= {CNT_W{1'b0}};
      halt_code_q <= HALT_EBREAK;
    end else begin
      state_q     <= state_d;
      instret_q   <= instret_d;
      halt_code_q <= halt_code_d;
    end
  end

  // Output stage: everything is forced low while reset is held.
  always_comb begin
    if (rst) begin
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      ir_en         = 1'b0;
      pc_en         = 1'b0;
      pc_sel_trap   = 1'b0;
      gpr_we        = 1'b0;
      halt          = 1'b0;
      halt_code     = 2'b00;
      instret       = {CNT_W{1'b0}};
    end else begin
      ifu_req_valid = ifu_req_valid_s;
      lsu_req_valid = lsu_req_valid_s;
      ir_en         = ir_en_s;
      pc_en         = pc_en_s;
      pc_sel_trap   = pc_sel_trap_s;
      gpr_we        = gpr_we_s;
      halt          = halt_s;
      halt_code     = halt_code_q;
      instret       = instret_q;
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: a small bus model answers the fetch and
// memory handshakes with programmable delays, and a scoreboard compares
// each instruction's outcome against a reference timing model.
module tb_cpu_seq_ctrl;

  localparam int CW = 8;
  localparam int TO = 4;
  localparam int K_WB   = 0;
  localparam int K_TRAP = 1;
  localparam int K_HALT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic          dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal;
  logic          lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic          ir_en, pc_en, pc_sel_trap, gpr_we, halt;
  logic [1:0]    halt_code;
  logic [CW-1:0] instret;

  cpu_seq_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_ebreak(dec_is_ebreak), .dec_illegal(dec_illegal),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel_trap(pc_sel_trap),
    .gpr_we(gpr_we), .halt(halt), .halt_code(halt_code), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f_rdy; int f_rsp; bit f_err;
    bit ld; bit st; bit eb; bit ill;
    int m_rdy; int m_rsp; bit m_err;
  } cfg_t;

  typedef struct {
    int kind; int lat; int ir_cyc; int lsu_cyc; int bad;
    logic gpr_we; logic trap_sel; logic halt; logic [1:0] code;
    logic nxt_req; logic [CW-1:0] instret;
  } res_t;

  res_t          sb_q[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  int            n_fail = 0;
  logic [CW-1:0] model_instret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zero_bus();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_err = 1'b0;
  endtask

  function automatic cfg_t mk(int f_rdy, int f_rsp, bit f_err, bit ld, bit st,
                              bit eb, bit ill, int m_rdy, int m_rsp, bit m_err);
    cfg_t c;
    c.f_rdy = f_rdy; c.f_rsp = f_rsp; c.f_err = f_err;
    c.ld = ld; c.st = st; c.eb = eb; c.ill = ill;
    c.m_rdy = m_rdy; c.m_rsp = m_rsp; c.m_err = m_err;
    return c;
  endfunction

  // Reference timing model; lat counts cycles from the first FETCH_REQ
  // cycle to the cycle showing pc_en or halt, inclusive. A response delay
  // of 0 means the bus never answers.
  function automatic res_t predict(input cfg_t c);
    res_t e;
    bit   f_to, m_to;
    e.kind = K_WB; e.lat = c.f_rdy + 1; e.ir_cyc = 0; e.lsu_cyc = 0;
    e.bad = 0; e.code = 2'b00; e.instret = '0;
    f_to = (c.f_rsp == 0) || (c.f_rsp > TO);
    m_to = (c.m_rsp == 0) || (c.m_rsp > TO);
    if (f_to) begin
      e.kind = K_HALT; e.code = 2'b01; e.lat += TO + 1;
    end else begin
      e.lat += c.f_rsp;
      if (c.f_err) begin
        e.kind = K_TRAP; e.lat += 1;
      end else begin
        e.ir_cyc = e.lat;
        e.lat += 1;
        if (c.ill) begin
          e.kind = K_TRAP; e.lat += 1;
        end else if (c.eb) begin
          e.kind = K_HALT; e.code = 2'b00; e.lat += 1;
        end else begin
          e.lat += 1;
          if (c.ld || c.st) begin
            e.lsu_cyc = c.m_rdy + 1;
            e.lat += c.m_rdy + 1;
            if (m_to) begin
              e.kind = K_HALT; e.code = 2'b10; e.lat += TO + 1;
            end else begin
              e.lat += c.m_rsp + 1;
              e.kind = c.m_err ? K_TRAP : K_WB;
            end
          end else begin
            e.lat += 1;
          end
        end
      end
    end
    e.gpr_we   = (e.kind == K_WB) && !c.st;
    e.trap_sel = (e.kind == K_TRAP);
    e.halt     = (e.kind == K_HALT);
    e.nxt_req  = (e.kind != K_HALT);
    return e;
  endfunction

  // Runs one instruction. Entered at posedge+1 of a FETCH_REQ cycle; leaves
  // at posedge+1 of the cycle after the terminal (pc_en or halt) cycle.
  task automatic run_instr(input cfg_t c, input string tag);
    res_t e, g;
    int   phase, fc, wc, mc;
    bit   done;
    e = predict(c);
    if (e.kind == K_WB) model_instret = model_instret + 8'd1;
    e.instret = model_instret;
    sb_q.push_back(e);

    dec_is_load = c.ld; dec_is_store = c.st;
    dec_is_ebreak = c.eb; dec_illegal = c.ill;
    phase = 0; fc = 0; wc = 0; mc = 0; done = 1'b0;
    g.kind = -1; g.lat = 0; g.ir_cyc = 0; g.lsu_cyc = 0; g.bad = 0;
    g.gpr_we = 1'b0; g.trap_sel = 1'b0; g.halt = 1'b0; g.code = 2'b00;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      zero_bus();
      case (phase)
        0: if (ifu_req_valid && fc == c.f_rdy) ifu_req_ready = 1'b1;
        1: if (wc == c.f_rsp) begin ifu_rsp_valid = 1'b1; ifu_rsp_err = c.f_err; end
        2: if (lsu_req_valid && mc == c.m_rdy) lsu_req_ready = 1'b1;
        3: if (wc == c.m_rsp) begin lsu_rsp_valid = 1'b1; lsu_rsp_err = c.m_err; end
        default: ;
      endcase
      @(negedge clk);
      if (lsu_req_valid) g.lsu_cyc++;
      if (ir_en && g.ir_cyc == 0) g.ir_cyc = cyc;
      if ((ir_en && (pc_en || gpr_we)) || (gpr_we && (!pc_en || pc_sel_trap)) ||
          (pc_sel_trap && !pc_en)) g.bad++;
      case (phase)
        0: if (ifu_req_valid) begin
             if (ifu_req_ready) begin phase = 1; wc = 1; end else fc++;
           end
        1: if (ifu_rsp_valid) phase = 2; else wc++;
        2: if (lsu_req_valid) begin
             if (lsu_req_ready) begin phase = 3; wc = 1; end else mc++;
           end
        3: if (lsu_rsp_valid) phase = 4; else wc++;
        default: ;
      endcase
      if (pc_en || halt) begin
        done = 1'b1;
        g.lat = cyc;
        g.kind = halt ? K_HALT : (pc_sel_trap ? K_TRAP : K_WB);
        g.gpr_we = gpr_we; g.trap_sel = pc_sel_trap;
        g.halt = halt; g.code = halt_code;
      end
      @(posedge clk); #1;
    end
    zero_bus();
    #1;
    g.nxt_req = ifu_req_valid;
    g.instret = instret;

    e = sb_q.pop_front();
    chk({tag, ".kind"},    64'(g.kind),     64'(e.kind));
    chk({tag, ".lat"},     64'(g.lat),      64'(e.lat));
    chk({tag, ".ir_cyc"},  64'(g.ir_cyc),   64'(e.ir_cyc));
    chk({tag, ".lsu_cyc"}, 64'(g.lsu_cyc),  64'(e.lsu_cyc));
    chk({tag, ".strobes"}, 64'(g.bad),      64'(e.bad));
    chk({tag, ".gpr_we"},  64'(g.gpr_we),   64'(e.gpr_we));
    chk({tag, ".trap"},    64'(g.trap_sel), 64'(e.trap_sel));
    chk({tag, ".halt"},    64'(g.halt),     64'(e.halt));
    if (e.kind == K_HALT) chk({tag, ".code"}, 64'(g.code), 64'(e.code));
    chk({tag, ".nxt_req"}, 64'(g.nxt_req),  64'(e.nxt_req));
    chk({tag, ".instret"}, 64'(g.instret),  64'(e.instret));
  endtask

  // Holds reset for two edges with busy bus inputs; outputs must stay low.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1;
    lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b1;
    #1;
    chk({tag, ".rst_outs"}, 64'({ifu_req_valid, lsu_req_valid, ir_en, pc_en,
        pc_sel_trap, gpr_we, halt, halt_code, instret}), 64'd0);
    zero_bus();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_instret = '0;
    #1;
    chk({tag, ".first_req"}, 64'(ifu_req_valid), 64'd1);
    chk({tag, ".instret0"},  64'(instret),       64'd0);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_ebreak = 1'b0; dec_illegal = 1'b0;
    zero_bus();
    model_instret = '0;

    do_reset("por");
    run_instr(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "alu");
    run_instr(mk(0, 1, 0, 1, 0, 0, 0, 3, 2, 0), "load");
    run_instr(mk(0, 1, 0, 0, 1, 0, 0, 3, 2, 0), "store");
    run_instr(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "fetch_err");
    run_instr(mk(1, 2, 0, 1, 0, 0, 0, 0, 1, 1), "mem_err");
    run_instr(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0), "ill_eb");
    run_instr(mk(2, 3, 0, 0, 0, 1, 0, 0, 0, 0), "ebreak");

    // Halted core must ignore a busy bus and keep every strobe low.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1;
      lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b1;
      @(negedge clk);
      if ({ifu_req_valid, lsu_req_valid, ir_en, pc_en, pc_sel_trap, gpr_we} != 6'b0 ||
          !halt || halt_code != 2'b00) bad++;
      @(posedge clk); #1;
    end
    zero_bus();
    chk("halt_quiet", 64'(bad), 64'd0);

    do_reset("rst_mto");
    run_instr(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0), "mem_timeout");
    do_reset("rst_mlast");
    run_instr(mk(0, 1, 0, 1, 0, 0, 0, 1, TO, 0), "mem_last_wait");
    run_instr(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_timeout");
    do_reset("rst_flast");
    run_instr(mk(2, TO, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_last_wait");

    // Retire enough instructions to wrap the 8-bit counter.
    for (int i = 0; i < 256; i++) run_instr(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "wrap");

    do_reset("rst_rand");
    for (int i = 0; i < 10; i++) begin
      int  sel;
      sel = int'($urandom_range(0, 2));
      run_instr(mk(int'($urandom_range(0, 3)), int'($urandom_range(1, TO)), 0,
                   sel == 1, sel == 2, 0, 0,
                   int'($urandom_range(0, 3)), int'($urandom_range(1, TO)), 0), "rand");
    end

    // Load held in MEM_WAIT, then reset mid-handshake.
    dec_is_load = 1'b1; dec_is_store = 1'b0; dec_is_ebreak = 1'b0; dec_illegal = 1'b0;
    ifu_req_ready = 1'b1;
    @(posedge clk); #1;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1;
    @(posedge clk); #1;
    ifu_rsp_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    lsu_req_ready = 1'b1;
    #1;
    chk("mr.lsu_req", 64'(lsu_req_valid), 64'd1);
    chk("mr.instret", 64'(instret), 64'(model_instret));
    @(posedge clk); #1;
    lsu_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mw_rst.outs", 64'({ifu_req_valid, lsu_req_valid, ir_en, pc_en,
        pc_sel_trap, gpr_we, halt, halt_code, instret}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_instret = '0;
    #1;
    chk("mw_rst.req",     64'(ifu_req_valid), 64'd1);
    chk("mw_rst.instret", 64'(instret),       64'd0);
    run_instr(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
